// File: rtl/btn_debounce_if.sv
// btn_debounce_if: tick/raw-button inputs and conditioned outputs of btn_debounce_multi.
// The slave modport is the debouncer; the master modport is whoever drives the buttons.
interface btn_debounce_if #(
   parameter int N_CH = 4
);
   logic            tick;
   logic [N_CH-1:0] btn;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] release_pulse;
   logic [N_CH-1:0] long_press;
   logic [N_CH-1:0] repeat_pulse;
   logic            press_any;

   modport master (
      output tick, btn,
      input  level, press, release_pulse, long_press, repeat_pulse, press_any
   );

   modport slave (
      input  tick, btn,
      output level, press, release_pulse, long_press, repeat_pulse, press_any
   );
endinterface

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: per-channel 2-FF synchroniser, tick-sampled debounce history and a
// hold FSM. release/repeat are SV keywords, so those outputs are release_pulse/repeat_pulse.
module btn_debounce_multi #(
   parameter int N_CH         = 4,
   parameter int DEPTH        = 8,
   parameter int LONG_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  logic          clk,
   input  logic          rst,
   btn_debounce_if.slave bus
);
   localparam int MAX_T = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int CW    = $clog2(MAX_T + 1);

   localparam logic [DEPTH-1:0] ONES    = {DEPTH{1'b1}};
   localparam logic [DEPTH-1:0] ZEROS   = {DEPTH{1'b0}};
   localparam logic [CW-1:0]    LONG_C  = CW'(LONG_TICKS);
   localparam logic [CW-1:0]    REP_C   = CW'(REPEAT_TICKS);
   localparam logic [CW-1:0]    HC_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0]    HC_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    HC_MAX  = {CW{1'b1}};

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      HELD     = 2'd2
   } state_t;

   logic [N_CH-1:0]  sync1_r;
   logic [N_CH-1:0]  sync2_r;
   logic [DEPTH-1:0] hist_r       [N_CH];
   logic [DEPTH-1:0] hist_next_s  [N_CH];
   state_t           state_r      [N_CH];
   state_t           state_next_s [N_CH];
   logic [CW-1:0]    hc_r         [N_CH];
   logic [CW-1:0]    hc_next_s    [N_CH];
   logic [CW-1:0]    hc_inc_s     [N_CH];
   logic [N_CH-1:0]  level_r;
   logic [N_CH-1:0]  level_next_s;
   logic [N_CH-1:0]  press_r;
   logic [N_CH-1:0]  press_next_s;
   logic [N_CH-1:0]  rel_r;
   logic [N_CH-1:0]  rel_next_s;
   logic [N_CH-1:0]  long_r;
   logic [N_CH-1:0]  long_next_s;
   logic [N_CH-1:0]  rep_r;
   logic [N_CH-1:0]  rep_next_s;
   logic             press_any_r;

   // Debounce decision and hold-FSM next state for every channel
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         hist_next_s[i]  = hist_r[i];
         level_next_s[i] = level_r[i];
         press_next_s[i] = 1'b0;
         rel_next_s[i]   = 1'b0;
         long_next_s[i]  = 1'b0;
         rep_next_s[i]   = 1'b0;
         state_next_s[i] = state_r[i];
         hc_next_s[i]    = hc_r[i];
         hc_inc_s[i]     = hc_r[i] + HC_ONE;
         if (bus.tick) begin
            hist_next_s[i] = {hist_r[i][DEPTH-2:0], sync2_r[i]};
            if ((hist_next_s[i] == ONES) && !level_r[i]) begin
               level_next_s[i] = 1'b1;
               press_next_s[i] = 1'b1;
            end else if ((hist_next_s[i] == ZEROS) && level_r[i]) begin
               level_next_s[i] = 1'b0;
               rel_next_s[i]   = 1'b1;
            end else begin
               level_next_s[i] = level_r[i];
            end
            // A release always takes priority over a completing hold count
            case (state_r[i])
               RELEASED: begin
                  if (press_next_s[i]) begin
                     state_next_s[i] = PRESSED;
                     hc_next_s[i]    = HC_ZERO;
                  end else begin
                     hc_next_s[i]    = HC_ZERO;
                  end
               end
               PRESSED: begin
                  if (rel_next_s[i]) begin
                     state_next_s[i] = RELEASED;
                     hc_next_s[i]    = HC_ZERO;
                  end else if (hc_inc_s[i] == LONG_C) begin
                     long_next_s[i]  = 1'b1;
                     state_next_s[i] = HELD;
                     hc_next_s[i]    = HC_ZERO;
                  end else begin
                     hc_next_s[i]    = hc_inc_s[i];
                  end
               end
               HELD: begin
                  if (rel_next_s[i]) begin
                     state_next_s[i] = RELEASED;
                     hc_next_s[i]    = HC_ZERO;
                  end else if (REPEAT_TICKS == 0) begin
                     if (hc_r[i] != HC_MAX) begin
                        hc_next_s[i] = hc_inc_s[i];
                     end else begin
                        hc_next_s[i] = hc_r[i];
                     end
                  end else if (hc_inc_s[i] == REP_C) begin
                     rep_next_s[i]   = 1'b1;
                     hc_next_s[i]    = HC_ZERO;
                  end else begin
                     hc_next_s[i]    = hc_inc_s[i];
                  end
               end
               default: begin
                  state_next_s[i] = RELEASED;
                  hc_next_s[i]    = HC_ZERO;
               end
            endcase
         end else begin
            hist_next_s[i] = hist_r[i];
         end
      end
   end

   // Synchroniser, history, level, FSM state and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r     <= {N_CH{1'b0}};
         sync2_r     <= {N_CH{1'b0}};
         level_r     <= {N_CH{1'b0}};
         press_r     <= {N_CH{1'b0}};
         rel_r       <= {N_CH{1'b0}};
         long_r      <= {N_CH{1'b0}};
         rep_r       <= {N_CH{1'b0}};
         press_any_r <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            hist_r[i]  <= ZEROS;
            state_r[i] <= RELEASED;
            hc_r[i]    <= HC_ZERO;
         end
      end else begin
         sync1_r     <= bus.btn;
         sync2_r     <= sync1_r;
         level_r     <= level_next_s;
         press_r     <= press_next_s;
         rel_r       <= rel_next_s;
         long_r      <= long_next_s;
         rep_r       <= rep_next_s;
         press_any_r <= |press_next_s;
         for (int i = 0; i < N_CH; i++) begin
            hist_r[i]  <= hist_next_s[i];
            state_r[i] <= state_next_s[i];
            hc_r[i]    <= hc_next_s[i];
         end
      end
   end

   assign bus.level         = level_r;
   assign bus.press         = press_r;
   assign bus.release_pulse = rel_r;
   assign bus.long_press    = long_r;
   assign bus.repeat_pulse  = rep_r;
   assign bus.press_any     = press_any_r;
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: two instances (repeat every 3 ticks / repeat disabled) driven with
// identical stimulus and compared every clk against a run-length/tick-count reference model.
module tb_btn_debounce_multi;
   localparam int NCH   = 2;
   localparam int DEPTH = 4;
   localparam int LONG  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   btn_debounce_if #(.N_CH(NCH)) if_a ();
   btn_debounce_if #(.N_CH(NCH)) if_b ();

   btn_debounce_multi #(.N_CH(NCH), .DEPTH(DEPTH), .LONG_TICKS(LONG), .REPEAT_TICKS(3))
      dut_a (.clk(clk), .rst(rst), .bus(if_a));
   btn_debounce_multi #(.N_CH(NCH), .DEPTH(DEPTH), .LONG_TICKS(LONG), .REPEAT_TICKS(0))
      dut_b (.clk(clk), .rst(rst), .bus(if_b));

   int checks = 0;
   int errors = 0;
   int rp [2] = '{3, 0};

   // Reference model: last sample value and how many ticks in a row it has been seen
   bit              m_sync1 [NCH];
   bit              m_sync2 [NCH];
   bit              run_val [NCH];
   int              run_len [NCH];
   bit              m_held  [2][NCH];
   int              m_t     [2][NCH];
   logic [NCH-1:0]  e_level, e_press, e_rel;
   logic [NCH-1:0]  e_long [2];
   logic [NCH-1:0]  e_rep  [2];
   logic            e_any;

   int c_press [NCH];
   int c_rel   [NCH];
   int c_long  [2][NCH];
   int c_rep   [2][NCH];
   int c_both;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic t, input logic [NCH-1:0] b);
      bit s;
      e_press = '0;
      e_rel   = '0;
      for (int v = 0; v < 2; v++) begin
         e_long[v] = '0;
         e_rep[v]  = '0;
      end
      if (r) begin
         e_level = '0;
         for (int ch = 0; ch < NCH; ch++) begin
            m_sync1[ch] = 1'b0;
            m_sync2[ch] = 1'b0;
            run_val[ch] = 1'b0;
            run_len[ch] = DEPTH;
            for (int v = 0; v < 2; v++) begin
               m_held[v][ch] = 1'b0;
               m_t[v][ch]    = 0;
            end
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) begin
            s = m_sync2[ch];
            m_sync2[ch] = m_sync1[ch];
            m_sync1[ch] = b[ch];
            if (t) begin
               if (s == run_val[ch]) begin
                  if (run_len[ch] < 1000) run_len[ch]++;
               end else begin
                  run_val[ch] = s;
                  run_len[ch] = 1;
               end
               if (run_len[ch] >= DEPTH && run_val[ch] != e_level[ch]) begin
                  e_level[ch] = run_val[ch];
                  if (run_val[ch]) e_press[ch] = 1'b1;
                  else             e_rel[ch]   = 1'b1;
               end
               for (int v = 0; v < 2; v++) begin
                  if (e_press[ch]) begin
                     m_held[v][ch] = 1'b1;
                     m_t[v][ch]    = 0;
                  end else if (e_rel[ch]) begin
                     m_held[v][ch] = 1'b0;
                     m_t[v][ch]    = 0;
                  end else if (m_held[v][ch]) begin
                     m_t[v][ch]++;
                     if (m_t[v][ch] == LONG) e_long[v][ch] = 1'b1;
                     else if (m_t[v][ch] > LONG && rp[v] != 0 && ((m_t[v][ch] - LONG) % rp[v]) == 0)
                        e_rep[v][ch] = 1'b1;
                  end
               end
            end
         end
      end
      e_any = |e_press;
   endtask

   task automatic clk1(input logic r, input logic t, input logic [NCH-1:0] b);
      rst       = r;
      if_a.tick = t;
      if_b.tick = t;
      if_a.btn  = b;
      if_b.btn  = b;
      @(posedge clk);
      #1;
      model_step(r, t, b);
      chk("a_level",   if_a.level,         e_level);
      chk("a_press",   if_a.press,         e_press);
      chk("a_release", if_a.release_pulse, e_rel);
      chk("a_long",    if_a.long_press,    e_long[0]);
      chk("a_repeat",  if_a.repeat_pulse,  e_rep[0]);
      chk("a_any",     if_a.press_any,     e_any);
      chk("b_level",   if_b.level,         e_level);
      chk("b_press",   if_b.press,         e_press);
      chk("b_release", if_b.release_pulse, e_rel);
      chk("b_long",    if_b.long_press,    e_long[1]);
      chk("b_repeat",  if_b.repeat_pulse,  e_rep[1]);
      chk("b_any",     if_b.press_any,     e_any);
      for (int ch = 0; ch < NCH; ch++) begin
         if (if_a.press[ch])         c_press[ch]++;
         if (if_a.release_pulse[ch]) c_rel[ch]++;
         if (if_a.long_press[ch])    c_long[0][ch]++;
         if (if_a.repeat_pulse[ch])  c_rep[0][ch]++;
         if (if_b.long_press[ch])    c_long[1][ch]++;
         if (if_b.repeat_pulse[ch])  c_rep[1][ch]++;
      end
      if (if_a.press == 2'b11 && if_a.press_any) c_both++;
   endtask

   // One tick window: four clks, btn changes at its start, tick on the last clk
   task automatic run(input logic [NCH-1:0] b, input int n);
      for (int w = 0; w < n; w++) begin
         for (int k = 0; k < 4; k++) clk1(1'b0, (k == 3), b);
      end
   endtask

   task automatic clr();
      c_both = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         c_press[ch] = 0;
         c_rel[ch]   = 0;
         for (int v = 0; v < 2; v++) begin
            c_long[v][ch] = 0;
            c_rep[v][ch]  = 0;
         end
      end
   endtask

   initial begin
      logic [NCH-1:0] b;
      clr();
      for (int k = 0; k < 3; k++) clk1(1'b1, 1'b0, 2'b00);
      chk("reset_level", if_a.level, 0);
      run(2'b00, 2);

      // Clean short press on ch0
      clr();
      run(2'b01, 6);
      run(2'b00, 8);
      chk("clean_press",   c_press[0],   1);
      chk("clean_release", c_rel[0],     1);
      chk("clean_nolong",  c_long[0][0], 0);

      // Bounce on ch1 before a steady press
      clr();
      run(2'b10, 1); run(2'b00, 1); run(2'b10, 2); run(2'b00, 1); run(2'b10, 1);
      run(2'b10, 6);
      run(2'b00, 8);
      chk("bounce_press",   c_press[1],   1);
      chk("bounce_release", c_rel[1],     1);
      chk("bounce_nolong",  c_long[0][1], 0);

      // Hold 22 ticks after press: long at 8, repeats at 11,14,17,20
      clr();
      run(2'b01, 22);
      run(2'b00, 8);
      chk("hold_press",  c_press[0],   1);
      chk("hold_rel",    c_rel[0],     1);
      chk("hold_long_a", c_long[0][0], 1);
      chk("hold_rep_a",  c_rep[0][0],  4);
      chk("hold_long_b", c_long[1][0], 1);
      chk("hold_rep_b",  c_rep[1][0],  0);

      // Long hold of 34 ticks
      clr();
      run(2'b01, 34);
      run(2'b00, 8);
      chk("long_rep_a",  c_rep[0][0],  8);
      chk("long_long_b", c_long[1][0], 1);
      chk("long_rep_b",  c_rep[1][0],  0);

      // Release lands exactly on the long-press tick
      clr();
      run(2'b01, 8);
      run(2'b00, 8);
      chk("coinc_rel",    c_rel[0],     1);
      chk("coinc_long_a", c_long[0][0], 0);
      chk("coinc_long_b", c_long[1][0], 0);

      // Reset while HELD with button still down
      run(2'b01, 14);
      clr();
      clk1(1'b1, 1'b0, 2'b01);
      chk("rst_rel",   if_a.release_pulse, 0);
      chk("rst_level", if_a.level,         0);
      clk1(1'b0, 1'b0, 2'b01);
      clk1(1'b0, 1'b0, 2'b01);
      clk1(1'b0, 1'b1, 2'b01);
      run(2'b01, 7);
      chk("rst_repress", c_press[0],   1);
      chk("rst_norel",   c_rel[0],     0);
      chk("rst_nolong",  c_long[0][0], 0);
      run(2'b00, 8);

      // Both channels pressed on the same tick
      clr();
      run(2'b11, 6);
      run(2'b00, 8);
      chk("both_press", c_both,   1);
      chk("both_rel1",  c_rel[1], 1);

      // Tick tied high, plus a 3-sample glitch on ch1
      clr();
      for (int k = 0; k < 14; k++) clk1(1'b0, 1'b1, 2'b01);
      for (int k = 0; k < 12; k++) clk1(1'b0, 1'b1, 2'b00);
      for (int k = 0; k < 3; k++)  clk1(1'b0, 1'b1, 2'b10);
      for (int k = 0; k < 12; k++) clk1(1'b0, 1'b1, 2'b00);
      chk("tickhi_press0", c_press[0], 1);
      chk("tickhi_rel0",   c_rel[0],   1);
      chk("glitch_press1", c_press[1], 0);

      // Randomised button activity, tick density and occasional reset
      b = 2'b00;
      for (int k = 0; k < 1500; k++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            if ($urandom_range(0, 23) == 0) b[ch] = ~b[ch];
         end
         clk1(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0), b);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
